// File: rtl/axi_burst_pkg.sv
// ============================================================================
// Module  : axi_burst_pkg
// Purpose : Shared widths, burst limit and FSM state encoding for the
//           axi_burst_master command-driven burst engine.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package axi_burst_pkg;

    localparam int DATA_W  = 32;
    localparam int MAX_LEN = 32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WREQ  = 3'd1,
        S_WDATA = 3'd2,
        S_RREQ  = 3'd3,
        S_RDATA = 3'd4,
        S_DONE  = 3'd5
    } state_e;

endpackage

`default_nettype wire

// File: rtl/axi_burst_master.sv
// ============================================================================
// Module  : axi_burst_master
// Purpose : Takes one read/write burst command at a time, issues the request
//           to the downstream slave and streams the beats through.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module axi_burst_master
    import axi_burst_pkg::*;
#(
    parameter int DATA_W  = axi_burst_pkg::DATA_W,
    parameter int MAX_LEN = axi_burst_pkg::MAX_LEN
) (
    input  logic              ARES_design_CLK,
    input  logic              ARES_design_RESET,

    input  logic              CMD_valid,
    output logic              CMD_ready,
    input  logic              CMD_write,
    input  logic [DATA_W-1:0] CMD_addr,
    input  logic [DATA_W-1:0] CMD_len,
    output logic              CMD_done,
    output logic              CMD_err,

    input  logic [DATA_W-1:0] WR_data,
    input  logic              WR_valid,
    output logic              WR_ready,

    output logic [DATA_W-1:0] RD_data,
    output logic              RD_valid,
    input  logic              RD_ready,

    output logic [DATA_W-1:0] MEM_WReq_addr,
    output logic [DATA_W-1:0] MEM_WReq_size,
    output logic              MEM_WReq_valid,
    input  logic              MEM_WReq_ready,
    output logic [DATA_W-1:0] MEM_W_data,
    output logic              MEM_W_valid,
    input  logic              MEM_W_ready,

    output logic [DATA_W-1:0] MEM_RReq_addr,
    output logic [DATA_W-1:0] MEM_RReq_size,
    output logic              MEM_RReq_valid,
    input  logic              MEM_RReq_ready,
    input  logic [DATA_W-1:0] MEM_R_data,
    input  logic              MEM_R_valid,
    output logic              MEM_R_ready
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] len_q,   len_d;
    logic [DATA_W-1:0] rem_q,   rem_d;
    logic              err_q,   err_d;

    always_ff @(posedge ARES_design_CLK or negedge ARES_design_RESET) begin
        if (!ARES_design_RESET) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        len_d          = len_q;
        rem_d          = rem_q;
        err_d          = err_q;

        CMD_ready      = 1'b0;
        CMD_done       = 1'b0;
        CMD_err        = 1'b0;
        WR_ready       = 1'b0;
        RD_data        = '0;
        RD_valid       = 1'b0;
        MEM_WReq_addr  = '0;
        MEM_WReq_size  = '0;
        MEM_WReq_valid = 1'b0;
        MEM_W_data     = '0;
        MEM_W_valid    = 1'b0;
        MEM_RReq_addr  = '0;
        MEM_RReq_size  = '0;
        MEM_RReq_valid = 1'b0;
        MEM_R_ready    = 1'b0;

        case (state_q)
            S_IDLE: begin
                CMD_ready = 1'b1;
                if (CMD_valid) begin
                    addr_d = CMD_addr;
                    len_d  = CMD_len;
                    if (CMD_len == '0) begin
                        state_d = S_DONE;
                    end else if (CMD_len > DATA_W'(MAX_LEN)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (CMD_write) begin
                        state_d = S_WREQ;
                    end else begin
                        state_d = S_RREQ;
                    end
                end
            end

            S_WREQ: begin
                MEM_WReq_valid = 1'b1;
                MEM_WReq_addr  = addr_q;
                MEM_WReq_size  = len_q;
                if (MEM_WReq_ready) begin
                    rem_d   = len_q;
                    state_d = S_WDATA;
                end
            end

            S_WDATA: begin
                MEM_W_valid = WR_valid;
                WR_ready    = MEM_W_ready;
                MEM_W_data  = WR_data;
                // The counter never wraps; the beat seen at one is the last.
                if (WR_valid && MEM_W_ready && rem_q != '0) begin
                    rem_d = rem_q - DATA_W'(1);
                    if (rem_q == DATA_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_RREQ: begin
                MEM_RReq_valid = 1'b1;
                MEM_RReq_addr  = addr_q;
                MEM_RReq_size  = len_q;
                if (MEM_RReq_ready) begin
                    rem_d   = len_q;
                    state_d = S_RDATA;
                end
            end

            S_RDATA: begin
                RD_valid    = MEM_R_valid;
                MEM_R_ready = RD_ready;
                RD_data     = MEM_R_data;
                if (MEM_R_valid && RD_ready && rem_q != '0) begin
                    rem_d = rem_q - DATA_W'(1);
                    if (rem_q == DATA_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                CMD_done = 1'b1;
                CMD_err  = err_q;
                err_d    = 1'b0;
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_axi_burst_master.sv
// ============================================================================
// Module  : tb_axi_burst_master
// Purpose : Self-checking bench for axi_burst_master with a behavioural
//           32-word slave and a reference memory image.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_axi_burst_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        CMD_valid = 1'b0, CMD_write = 1'b0;
    logic [31:0] CMD_addr = '0, CMD_len = '0;
    logic        CMD_ready, CMD_done, CMD_err;
    logic [31:0] WR_data = '0;
    logic        WR_valid = 1'b0, WR_ready;
    logic [31:0] RD_data;
    logic        RD_valid, RD_ready = 1'b0;
    logic [31:0] MEM_WReq_addr, MEM_WReq_size, MEM_W_data;
    logic        MEM_WReq_valid, MEM_WReq_ready, MEM_W_valid, MEM_W_ready;
    logic [31:0] MEM_RReq_addr, MEM_RReq_size, MEM_R_data;
    logic        MEM_RReq_valid, MEM_RReq_ready, MEM_R_valid, MEM_R_ready;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] ref_mem [0:31];
    logic [31:0] force_q [$];

    always #5 clk = ~clk;

    axi_burst_master dut (
        .ARES_design_CLK   (clk),
        .ARES_design_RESET (rst_n),
        .CMD_valid         (CMD_valid),
        .CMD_ready         (CMD_ready),
        .CMD_write         (CMD_write),
        .CMD_addr          (CMD_addr),
        .CMD_len           (CMD_len),
        .CMD_done          (CMD_done),
        .CMD_err           (CMD_err),
        .WR_data           (WR_data),
        .WR_valid          (WR_valid),
        .WR_ready          (WR_ready),
        .RD_data           (RD_data),
        .RD_valid          (RD_valid),
        .RD_ready          (RD_ready),
        .MEM_WReq_addr     (MEM_WReq_addr),
        .MEM_WReq_size     (MEM_WReq_size),
        .MEM_WReq_valid    (MEM_WReq_valid),
        .MEM_WReq_ready    (MEM_WReq_ready),
        .MEM_W_data        (MEM_W_data),
        .MEM_W_valid       (MEM_W_valid),
        .MEM_W_ready       (MEM_W_ready),
        .MEM_RReq_addr     (MEM_RReq_addr),
        .MEM_RReq_size     (MEM_RReq_size),
        .MEM_RReq_valid    (MEM_RReq_valid),
        .MEM_RReq_ready    (MEM_RReq_ready),
        .MEM_R_data        (MEM_R_data),
        .MEM_R_valid       (MEM_R_valid),
        .MEM_R_ready       (MEM_R_ready)
    );

    // Behavioural slave: request accepted only when idle, one count-load
    // cycle, then beats with optional random back-pressure.
    logic [31:0] s_ram [0:31];
    logic [31:0] s_waddr, s_wcnt, s_wpend, s_raddr, s_rcnt, s_rpend;
    logic        s_wload, s_rload;
    logic        s_wstall = 1'b0, s_rstall = 1'b0;

    assign MEM_WReq_ready = (s_wcnt == 0) && !s_wload;
    assign MEM_W_ready    = (s_wcnt != 0) && !s_wstall;
    assign MEM_RReq_ready = (s_rcnt == 0) && !s_rload;
    assign MEM_R_valid    = (s_rcnt != 0) && !s_rstall;
    assign MEM_R_data     = MEM_R_valid ? s_ram[s_raddr[4:0]] : 32'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_waddr <= '0; s_wcnt <= '0; s_wpend <= '0; s_wload <= 1'b0;
            s_raddr <= '0; s_rcnt <= '0; s_rpend <= '0; s_rload <= 1'b0;
        end else begin
            if (MEM_WReq_valid && MEM_WReq_ready) begin
                s_wload <= 1'b1; s_waddr <= MEM_WReq_addr; s_wpend <= MEM_WReq_size;
            end else if (s_wload) begin
                s_wload <= 1'b0; s_wcnt <= s_wpend;
            end else if (MEM_W_valid && MEM_W_ready) begin
                s_waddr <= s_waddr + 1; s_wcnt <= s_wcnt - 1;
            end
            if (MEM_RReq_valid && MEM_RReq_ready) begin
                s_rload <= 1'b1; s_raddr <= MEM_RReq_addr; s_rpend <= MEM_RReq_size;
            end else if (s_rload) begin
                s_rload <= 1'b0; s_rcnt <= s_rpend;
            end else if (MEM_R_valid && MEM_R_ready) begin
                s_raddr <= s_raddr + 1; s_rcnt <= s_rcnt - 1;
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && MEM_W_valid && MEM_W_ready)
            s_ram[s_waddr[4:0]] <= MEM_W_data;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_cmd_ready", CMD_ready, 1);
        chk("rst_done_err", {CMD_done, CMD_err}, 0);
        chk("rst_valids", {MEM_WReq_valid, MEM_W_valid, MEM_RReq_valid, RD_valid}, 0);
        chk("rst_readies", {MEM_R_ready, WR_ready}, 0);
        chk("rst_waddr", MEM_WReq_addr | MEM_WReq_size, 0);
        chk("rst_raddr", MEM_RReq_addr | MEM_RReq_size, 0);
        chk("rst_rd_data", RD_data, 0);
    endtask

    // One command end to end: drive, watch every cycle, then score against
    // the reference memory and the latency rules.
    task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] len,
                           input int stall_pct, input bit pattern, input bit hold_valid);
        logic [31:0] wdata [$];
        bit legal, done;
        int cyc, beats, req_cyc, last_cyc, done_cyc;
        legal = (len != 0) && (len <= 32);
        if (legal) begin
            for (int i = 0; i < int'(len); i++)
                wdata.push_back(force_q.size() != 0 ? force_q.pop_front() : $urandom);
        end
        @(negedge clk);
        chk("idle_ready", CMD_ready, 1);
        CMD_valid = 1'b1; CMD_write = wr; CMD_addr = addr; CMD_len = len;
        @(negedge clk);
        if (hold_valid) begin
            CMD_write = !wr; CMD_addr = 32'd1; CMD_len = 32'd1;
        end else begin
            CMD_valid = 1'b0;
        end
        done = 0; cyc = 1; beats = 0; req_cyc = 0; last_cyc = 0; done_cyc = 0;
        while (!done && cyc < 400) begin
            WR_valid = (stall_pct == 0) || ($urandom_range(99) >= stall_pct);
            WR_data  = (beats < wdata.size()) ? wdata[beats] : $urandom;
            RD_ready = pattern ? (cyc % 3 == 0) :
                       ((stall_pct == 0) || ($urandom_range(99) >= stall_pct));
            s_wstall = (stall_pct != 0) && ($urandom_range(99) < stall_pct);
            s_rstall = (stall_pct != 0) && ($urandom_range(99) < stall_pct);
            #3;
            chk("busy_ready", CMD_ready, 0);
            if (wr) chk("rd_blocked", {RD_valid, MEM_R_ready}, 0);
            else    chk("wr_blocked", {WR_ready, MEM_W_valid}, 0);
            if (MEM_WReq_valid || MEM_RReq_valid) begin
                req_cyc++;
                chk("req_dir", {MEM_WReq_valid, MEM_RReq_valid}, wr ? 2 : 1);
                chk("req_addr", wr ? MEM_WReq_addr : MEM_RReq_addr, addr);
                chk("req_size", wr ? MEM_WReq_size : MEM_RReq_size, len);
            end
            if (wr && WR_valid && WR_ready) begin
                beats++; last_cyc = cyc;
            end
            if (!wr && RD_valid && RD_ready) begin
                chk("rd_data", RD_data, ref_mem[(addr + beats) & 31]);
                beats++; last_cyc = cyc;
            end
            if (CMD_done) begin
                done = 1; done_cyc = cyc;
                chk("cmd_err", CMD_err, (len != 0) && !legal);
            end
            @(negedge clk);
            cyc++;
        end
        CMD_valid = 1'b0; WR_valid = 1'b0; RD_ready = 1'b0;
        s_wstall = 1'b0; s_rstall = 1'b0;
        chk("done_seen", done, 1);
        chk("beats", beats, legal ? len : 0);
        chk("req_cycles", req_cyc, legal ? 1 : 0);
        if (legal) chk("done_after_last", done_cyc, last_cyc + 1);
        else       chk("done_latency", done_cyc, 1);
        if (legal && stall_pct == 0 && !pattern)
            chk("burst_latency", done_cyc, len + 3);
        if (wr && legal) begin
            for (int i = 0; i < int'(len); i++) begin
                ref_mem[(addr + i) & 31] = wdata[i];
                chk("ram", s_ram[(addr + i) & 31], wdata[i]);
            end
        end
    endtask

    initial begin
        logic [31:0] a, l;
        int          sel, seen;
        repeat (2) @(negedge clk);
        chk_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs();

        // Fill the slave memory so every later read has a known image.
        run_cmd(1, 0, 32, 0, 0, 0);

        force_q = '{32'hA, 32'hB, 32'hC};
        run_cmd(1, 4, 3, 0, 0, 0);
        run_cmd(0, 4, 3, 0, 0, 0);
        run_cmd(0, 7, 4, 0, 1, 0);
        run_cmd(1, 9, 0, 0, 0, 0);
        run_cmd(0, 9, 33, 0, 0, 0);
        run_cmd(1, 12, 2, 0, 0, 1);

        // Abort a 5-beat write right after its first beat.
        @(negedge clk);
        CMD_valid = 1'b1; CMD_write = 1'b1; CMD_addr = 32'd10; CMD_len = 32'd5;
        @(negedge clk);
        CMD_valid = 1'b0; WR_valid = 1'b1; WR_data = 32'hDEAD_0001;
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            #3;
            if (WR_valid && WR_ready) seen = 1;
            @(negedge clk);
        end
        chk("abort_first_beat", seen, 1);
        ref_mem[10] = 32'hDEAD_0001;
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs();
        WR_valid = 1'b0;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (CMD_done) seen = 1;
        end
        chk("abort_no_done", seen, 0);
        rst_n = 1'b1;
        run_cmd(1, 20, 1, 0, 0, 0);
        run_cmd(0, 9, 3, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            a   = $urandom_range(31);
            sel = $urandom_range(9);
            if (sel == 0)      l = 0;
            else if (sel == 1) l = 33 + $urandom_range(20);
            else if (sel == 2) l = 32'hFFFF_FF00 | $urandom_range(255);
            else               l = 1 + $urandom_range(31);
            run_cmd($urandom_range(1), a, l, (n % 3 == 0) ? 0 : $urandom_range(60),
                    0, $urandom_range(3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
